fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, the PC loaded at reset.
REQ-002 Parameter IM_AWIDTH, default 10, the instruction-memory word-address width (1024 words, 4 KB).
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 start  input  1  leave IDLE/HALT and begin fetching.
REQ-006 halt  input  1  stop issuing fetches; queue drains.
REQ-007 redirect  input  1  branch/jump; flush queue and load redirect_pc.
REQ-008 redirect_pc  input  32  new fetch byte address.
REQ-009 im_addr  output  32  byte address to the instruction memory (current PC).
REQ-010 im_inst  input  32  combinational read data from the instruction memory for im_addr.
REQ-011 inst_valid  output  1  queue head holds a valid instruction.
REQ-012 inst_ready  input  1  consumer accepts head this cycle.
REQ-013 inst_out  output  32  instruction word at queue head.
REQ-014 inst_pc  output  32  byte address of inst_out.
REQ-015 busy  output  1  high while in FETCH.
REQ-016 fault  output  1  sticky illegal-redirect indicator.

Function
REQ-017 FSM states IDLE, FETCH, HALT, FAULT; event priority rst > fault detection > redirect > halt > start/normal fetch.
REQ-018 IDLE: start=1 -> FETCH next cycle; redirect loads PC, stays IDLE.
REQ-019 FETCH: each cycle push {pc, im_inst} into 2-entry queue and pc <= pc+4 when queue not full, or full with a pop this cycle; otherwise pc holds.
REQ-020 PC held within 4 KB: pc[31:12] always 0, pc[1:0] always 0; after 32'h0000_0FFC next PC is 32'h0000_0000; im_addr = pc.
REQ-021 Handshake: transfer when inst_valid && inst_ready; inst_out/inst_pc stable while inst_valid && !inst_ready.
REQ-022 inst_valid = queue not empty && !redirect (combinational mask).
REQ-023 Latency: instruction addressed in cycle N is available at head in cycle N+1 when queue was empty; start sampled in cycle N gives im_addr=RESET_PC in N+1, inst_valid=1 in N+2.
REQ-024 Redirect with redirect_pc[1:0]==0 and redirect_pc[31:12]==0: queue flushed, no push, no pop, pc <= redirect_pc that cycle; state unchanged unless halt also high (then HALT).
REQ-025 Redirect with misaligned or out-of-range redirect_pc: queue flushed, state FAULT, fault=1 until rst; FAULT ignores all inputs, inst_valid=0.
REQ-026 halt in FETCH (no redirect): no push that cycle, -> HALT; pops continue until empty.
REQ-027 HALT: start=1 -> FETCH resuming at current pc; redirect updates pc, stays HALT.
REQ-028 Simultaneous start and halt in HALT: halt wins, stays HALT.
REQ-029 busy = (state==FETCH); no push occurs outside FETCH.

Reset
REQ-030 On rst: state IDLE, pc=RESET_PC, queue empty, inst_valid=0, inst_out=0, inst_pc=0, busy=0, fault=0.
REQ-031 rst mid-operation discards queued instructions and fault in the same edge.

Structure
REQ-032 Shared package holds state encodings (IDLE=2'b00, FETCH=2'b01, HALT=2'b10, FAULT=2'b11), IM_AWIDTH default, PC step constant 4.
REQ-033 Queue is sub-module fetch_fifo: 2-entry, 64-bit {pc, inst}, push/pop/flush, full/empty flags, simultaneous push+pop when full allowed.

Verification
REQ-034 Reset, start, inst_ready=1, memory word k = 32'h1000_0000+k -> from cycle N+2, one instruction per cycle, inst_pc 0,4,8,... matching data.
REQ-035 inst_ready=0 for 5 cycles while fetching -> queue fills at 2 entries, pc stops at head_pc+8, inst_out stable, no lost or duplicated word on release.
REQ-036 redirect with redirect_pc=32'h0000_0100 while queue holds 2 entries -> inst_valid=0 that cycle, next instruction delivered has inst_pc=0x100.
REQ-037 Fetch to 32'h0000_0FFC -> following inst_pc is 32'h0000_0000.
REQ-038 redirect_pc=32'h0000_0102, then separately 32'h0000_1000 after reset -> fault=1, busy=0, inst_valid=0 until rst; rst clears fault.
REQ-039 halt at pc=0x20 with 1 entry queued -> entry drains, no further fetch; start -> fetching resumes at im_addr=0x20.

Source files
------------

// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the instruction fetch controller: FSM encodings,
// queue entry layout, PC stepping constants and the PC range mask helper.
package fetch_ctrl_pkg;

    localparam int unsigned IM_AWIDTH_DEF = 10;
    localparam int unsigned FIFO_DEPTH    = 2;
    localparam logic [31:0] PC_STEP       = 32'd4;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FETCH = 2'b01,
        HALT  = 2'b10,
        FAULT = 2'b11
    } state_t;

    // One queued fetch: byte address plus the word read from that address.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    // Legal PC bits for a word-addressed memory of 2**awidth words:
    // word-aligned and inside the memory span.
    function automatic logic [31:0] pc_mask(input int unsigned awidth);
        logic [63:0] span;
        span = (64'd1 << (awidth + 32'd2)) - 64'd1;
        return 32'(span) & ~32'd3;
    endfunction

endpackage

// File: rtl/fetch_ctrl_fifo.sv
// Two-entry fetch queue holding {pc, inst}.
// Ports: clk, rst (sync, active-high), push/pop/flush controls, din entry,
// head entry (slot 0), full and empty flags. Push with pop while full is
// allowed; callers never pop when empty nor push when full without a pop.
module fetch_fifo
    import fetch_ctrl_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t din,
    output fetch_entry_t head,
    output logic         full,
    output logic         empty
);

    logic [1:0]   count;
    fetch_entry_t slot0;
    fetch_entry_t slot1;

    // Slot 0 is always the head; a pop shifts slot 1 forward.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            slot0 <= '0;
            slot1 <= '0;
        end else if (flush) begin
            count <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) slot0 <= din;
                    else               slot1 <= din;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    slot0 <= slot1;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        slot0 <= din;
                    end else begin
                        slot0 <= slot1;
                        slot1 <= din;
                    end
                end
                default: ;
            endcase
        end
    end

    assign head  = slot0;
    assign full  = (count == 2'(FIFO_DEPTH));
    assign empty = (count == 2'd0);

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: walks a PC through a small instruction
// memory, queues {pc, inst} pairs and hands them to a consumer with a
// valid/ready handshake. Supports start/halt, redirects and a sticky fault
// on illegal redirect targets.
// Ports: clk, rst (sync, active-high), start, halt, redirect, redirect_pc,
// im_addr/im_inst (memory side), inst_valid/inst_ready/inst_out/inst_pc
// (consumer side), busy (in FETCH), fault (sticky until rst).
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned IM_AWIDTH = IM_AWIDTH_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        halt,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] im_addr,
    input  logic [31:0] im_inst,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_out,
    output logic [31:0] inst_pc,
    output logic        busy,
    output logic        fault
);

    localparam logic [31:0] PC_MASK = pc_mask(IM_AWIDTH);

    state_t       state;
    state_t       state_nxt;
    logic [31:0]  pc;
    logic [31:0]  pc_nxt;
    logic         push;
    logic         pop;
    logic         flush;
    logic         redirect_ok;
    logic         q_full;
    logic         q_empty;
    fetch_entry_t q_head;
    fetch_entry_t q_din;

    // State and PC registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            pc    <= RESET_PC & PC_MASK;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
        end
    end

    // Next state, PC and queue control. FAULT is absorbing until reset.
    always_comb begin
        state_nxt   = state;
        pc_nxt      = pc;
        push        = 1'b0;
        flush       = 1'b0;
        redirect_ok = ((redirect_pc & ~PC_MASK) == 32'd0);
        if (state != FAULT) begin
            if (redirect) begin
                flush = 1'b1;
                if (!redirect_ok) begin
                    state_nxt = FAULT;
                end else begin
                    pc_nxt = redirect_pc;
                    if (halt) state_nxt = HALT;
                end
            end else if (halt) begin
                if (state == FETCH) state_nxt = HALT;
            end else if (start) begin
                state_nxt = FETCH;
            end
            // Fetch only when the queue can take the word this cycle.
            if (state == FETCH && !redirect && !halt && (!q_full || pop)) begin
                push   = 1'b1;
                pc_nxt = (pc + PC_STEP) & PC_MASK;
            end
        end
    end

    // Redirect masks the head combinationally so a flushed word is never taken.
    assign inst_valid = !q_empty && !redirect && (state != FAULT);
    assign pop        = inst_valid && inst_ready;
    assign q_din      = '{pc: pc, inst: im_inst};

    fetch_fifo u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .din   (q_din),
        .head  (q_head),
        .full  (q_full),
        .empty (q_empty)
    );

    assign im_addr  = pc;
    assign inst_out = q_head.inst;
    assign inst_pc  = q_head.pc;
    assign busy     = (state == FETCH);
    assign fault    = (state == FAULT);

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl. Memory word k holds 32'h1000_0000 + k.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        halt;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] im_addr;
    logic [31:0] im_inst;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;
    logic        busy;
    logic        fault;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign im_inst = 32'h1000_0000 + (im_addr >> 2);

    fetch_ctrl #(
        .RESET_PC  (32'h0000_0000),
        .IM_AWIDTH (10)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .halt        (halt),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .im_addr     (im_addr),
        .im_inst     (im_inst),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .inst_out    (inst_out),
        .inst_pc     (inst_pc),
        .busy        (busy),
        .fault       (fault)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; halt = 1'b0; redirect = 1'b0;
        redirect_pc = 32'd0; inst_ready = 1'b0;
        repeat (2) step();
        check("rst_valid", 32'(inst_valid), 32'd0);
        check("rst_out",   inst_out, 32'd0);
        check("rst_pc",    inst_pc, 32'd0);
        check("rst_busy",  32'(busy), 32'd0);
        check("rst_fault", 32'(fault), 32'd0);
        check("rst_addr",  im_addr, 32'd0);
        rst = 1'b0;
        step();
        check("idle_busy", 32'(busy), 32'd0);

        // Start and streaming with ready held high.
        inst_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        check("start_busy",  32'(busy), 32'd1);
        check("start_addr",  im_addr, 32'd0);
        check("start_valid", 32'(inst_valid), 32'd0);
        step();
        for (int k = 0; k < 8; k++) begin
            check("stream_valid", 32'(inst_valid), 32'd1);
            check("stream_pc",    inst_pc, 32'(4 * k));
            check("stream_out",   inst_out, 32'h1000_0000 + 32'(k));
            step();
        end

        // Backpressure: queue fills, PC stops two words past the head.
        inst_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("stall_pc", inst_pc, 32'h20);
        end
        check("stall_out",   inst_out, 32'h1000_0008);
        check("stall_addr",  im_addr, 32'h28);
        check("stall_valid", 32'(inst_valid), 32'd1);
        inst_ready = 1'b1;
        for (int k = 8; k < 12; k++) begin
            check("release_pc",  inst_pc, 32'(4 * k));
            check("release_out", inst_out, 32'h1000_0000 + 32'(k));
            step();
        end

        // Redirect with a full queue.
        redirect = 1'b1; redirect_pc = 32'h100;
        #1;
        check("redir_mask", 32'(inst_valid), 32'd0);
        step();
        redirect = 1'b0;
        check("redir_empty", 32'(inst_valid), 32'd0);
        check("redir_addr",  im_addr, 32'h100);
        check("redir_busy",  32'(busy), 32'd1);
        step();
        check("redir_valid", 32'(inst_valid), 32'd1);
        check("redir_pc",    inst_pc, 32'h100);
        check("redir_out",   inst_out, 32'h1000_0040);

        // Halt at pc=0x20 with one entry queued.
        redirect = 1'b1; redirect_pc = 32'h1C;
        step();
        redirect = 1'b0;
        step();
        inst_ready = 1'b0; halt = 1'b1;
        #1;
        check("pre_halt_pc",   inst_pc, 32'h1C);
        check("pre_halt_addr", im_addr, 32'h20);
        step();
        halt = 1'b0;
        check("halt_busy",  32'(busy), 32'd0);
        check("halt_valid", 32'(inst_valid), 32'd1);
        check("halt_pc",    inst_pc, 32'h1C);
        check("halt_addr",  im_addr, 32'h20);
        inst_ready = 1'b1;
        step();
        check("drain_valid", 32'(inst_valid), 32'd0);
        repeat (2) step();
        check("halt_nofetch", im_addr, 32'h20);
        start = 1'b1; halt = 1'b1;
        step();
        check("halt_wins", 32'(busy), 32'd0);
        halt = 1'b0;
        step();
        start = 1'b0;
        check("resume_busy",  32'(busy), 32'd1);
        check("resume_addr",  im_addr, 32'h20);
        check("resume_valid", 32'(inst_valid), 32'd0);
        step();
        check("resume_pc",  inst_pc, 32'h20);
        check("resume_out", inst_out, 32'h1000_0008);

        // Wrap from the top of the 4 KB window.
        redirect = 1'b1; redirect_pc = 32'hFF8;
        step();
        redirect = 1'b0;
        step();
        check("wrap_pc0",  inst_pc, 32'hFF8);
        check("wrap_out0", inst_out, 32'h1000_03FE);
        step();
        check("wrap_pc1",  inst_pc, 32'hFFC);
        check("wrap_out1", inst_out, 32'h1000_03FF);
        step();
        check("wrap_pc2",  inst_pc, 32'h0);
        check("wrap_out2", inst_out, 32'h1000_0000);

        // Misaligned redirect faults; fault is sticky and ignores inputs.
        redirect = 1'b1; redirect_pc = 32'h102;
        #1;
        check("mis_mask", 32'(inst_valid), 32'd0);
        step();
        redirect = 1'b0;
        check("mis_fault", 32'(fault), 32'd1);
        check("mis_busy",  32'(busy), 32'd0);
        check("mis_valid", 32'(inst_valid), 32'd0);
        start = 1'b1; redirect = 1'b1; redirect_pc = 32'h40;
        repeat (3) step();
        start = 1'b0; redirect = 1'b0;
        check("sticky_fault", 32'(fault), 32'd1);
        check("sticky_busy",  32'(busy), 32'd0);
        check("sticky_valid", 32'(inst_valid), 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("clr_fault", 32'(fault), 32'd0);
        check("clr_busy",  32'(busy), 32'd0);
        check("clr_addr",  im_addr, 32'd0);

        // Legal redirect in IDLE loads the PC and stays idle.
        redirect = 1'b1; redirect_pc = 32'h40;
        step();
        redirect = 1'b0;
        check("idle_redir_busy", 32'(busy), 32'd0);
        check("idle_redir_addr", im_addr, 32'h40);

        // Out-of-range redirect faults.
        redirect = 1'b1; redirect_pc = 32'h1000;
        step();
        redirect = 1'b0;
        check("oor_fault", 32'(fault), 32'd1);
        check("oor_busy",  32'(busy), 32'd0);
        check("oor_valid", 32'(inst_valid), 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("oor_clr", 32'(fault), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
